// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port across N_REQ requesters; answers are routed back in issue order.
// Request is registered (1 cycle to mem_req_valid_o); grants stall on full tracking or held output.
module mem_port_arbiter #(
   parameter int N_REQ           = 3,
   parameter int MAX_OUTSTANDING = 4,
   parameter int XLEN            = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [N_REQ-1:0]      flush_i,
   input  logic [N_REQ-1:0]      req_valid_i,
   output logic [N_REQ-1:0]      req_ready_o,
   input  logic [N_REQ*XLEN-1:0] req_addr_i,
   input  logic [N_REQ-1:0]      req_we_i,
   input  logic [N_REQ*8-1:0]    req_be_i,
   input  logic [N_REQ*XLEN-1:0] req_wdata_i,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic [XLEN-1:0]       mem_req_addr_o,
   output logic                  mem_req_we_o,
   output logic [7:0]            mem_req_be_o,
   output logic [XLEN-1:0]       mem_req_wdata_o,
   input  logic                  mem_ans_valid_i,
   output logic                  mem_ans_ready_o,
   input  logic [XLEN-1:0]       mem_ans_rdata_i,
   input  logic                  mem_ans_err_i,
   output logic [N_REQ-1:0]      ans_valid_o,
   input  logic [N_REQ-1:0]      ans_ready_i,
   output logic [XLEN-1:0]       ans_rdata_o,
   output logic                  ans_err_o
);

   localparam int PW  = $clog2(MAX_OUTSTANDING);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic            we;
      logic [7:0]      be;
      logic [XLEN-1:0] wdata;
   } req_t;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic           drop;
   } meta_t;

   meta_t           fifo_q [MAX_OUTSTANDING];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PW:0]     count_q;
   logic [IDW-1:0]  rr_q;
   req_t            out_q;
   logic            out_vld_q;

   logic [N_REQ-1:0] eff_valid;
   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   logic             capture, push, pop, fifo_empty;
   logic [IDW-1:0]   head_id;
   logic             head_drop;
   req_t             req_nxt;

   // A flushed requester's request is masked so it cannot win this cycle.
   assign eff_valid = req_valid_i & ~flush_i;

   always_comb begin
      int scan;
      scan      = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan = int'(rr_q) + k;
         if (scan >= N_REQ) scan = scan - N_REQ;
         if (!gnt_found && eff_valid[scan]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(scan);
         end
      end
   end

   assign capture = rst_ni && (count_q < (PW+1)'(MAX_OUTSTANDING))
                    && (!out_vld_q || mem_req_ready_i);
   assign push    = capture && gnt_found;

   always_comb begin
      req_ready_o = '0;
      if (push) req_ready_o[gnt_idx] = 1'b1;
   end

   always_comb begin
      req_nxt.addr  = req_addr_i[int'(gnt_idx)*XLEN +: XLEN];
      req_nxt.we    = req_we_i[gnt_idx];
      req_nxt.be    = req_be_i[int'(gnt_idx)*8 +: 8];
      req_nxt.wdata = req_wdata_i[int'(gnt_idx)*XLEN +: XLEN];
   end

   assign fifo_empty = (count_q == '0);
   assign head_id    = fifo_q[rd_ptr_q].id;
   // A same-cycle flush of the head's owner discards its answer immediately.
   assign head_drop  = fifo_q[rd_ptr_q].drop | flush_i[head_id];

   always_comb begin
      ans_valid_o     = '0;
      mem_ans_ready_o = 1'b0;
      if (!fifo_empty) begin
         if (head_drop) begin
            mem_ans_ready_o = 1'b1;
         end else begin
            ans_valid_o[head_id] = mem_ans_valid_i;
            mem_ans_ready_o      = ans_ready_i[head_id];
         end
      end
   end

   assign pop         = mem_ans_valid_i && mem_ans_ready_o;
   assign ans_rdata_o = mem_ans_rdata_i;
   assign ans_err_o   = mem_ans_err_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int e = 0; e < MAX_OUTSTANDING; e++) fifo_q[e] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rr_q      <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         for (int e = 0; e < MAX_OUTSTANDING; e++) begin
            if (flush_i[fifo_q[e].id]) fifo_q[e].drop <= 1'b1;
         end
         if (push) begin
            fifo_q[wr_ptr_q] <= '{id: gnt_idx, drop: flush_i[gnt_idx]};
            wr_ptr_q         <= wr_ptr_q + PW'(1);
            out_q            <= req_nxt;
            out_vld_q        <= 1'b1;
            rr_q             <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + IDW'(1);
         end else if (mem_req_ready_i) begin
            out_vld_q <= 1'b0;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !pop)      count_q <= count_q + (PW+1)'(1);
         else if (!push && pop) count_q <= count_q - (PW+1)'(1);
      end
   end

   assign mem_req_valid_o = out_vld_q;
   assign mem_req_addr_o  = out_q.addr;
   assign mem_req_we_o    = out_q.we;
   assign mem_req_be_o    = out_q.be;
   assign mem_req_wdata_o = out_q.wdata;

   ans_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(mem_ans_valid_i && fifo_empty));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core-side memory port between the fetch unit (requester 0), load buffer (requester 1) and store buffer (requester 2).
- Arbitrates requests round-robin and registers the winning request toward memory.
- Tracks outstanding transactions in an in-order ID FIFO and routes each memory answer back to the requester that issued it.
- Per-requester flush discards answers belonging to squashed requests, so the pipeline can recover without waiting for memory.

Parameters:
- N_REQ, 3: number of requesters; index 0 has the highest priority after reset.
- MAX_OUTSTANDING, 4: outstanding-transaction capacity (power of 2, ≥2). Includes the request held in the output register.
- XLEN, 64: address/data width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  N_REQ  per-requester flush: drop pending answers for requester i
- req_valid_i  in  N_REQ  request valid, one bit per requester
- req_ready_o  out  N_REQ  request accepted, one-hot or zero
- req_addr_i  in  N_REQ*XLEN  request address, packed per requester
- req_we_i  in  N_REQ  write enable (1 = store)
- req_be_i  in  N_REQ*8  byte enables
- req_wdata_i  in  N_REQ*XLEN  write data
- mem_req_valid_o  out  1  memory request valid (registered)
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  XLEN  memory request address
- mem_req_we_o  out  1  memory write enable
- mem_req_be_o  out  8  memory byte enables
- mem_req_wdata_o  out  XLEN  memory write data
- mem_ans_valid_i  in  1  memory answer valid; answers return in issue order, one per request, stores included
- mem_ans_ready_o  out  1  arbiter accepts the answer
- mem_ans_rdata_i  in  XLEN  answer data
- mem_ans_err_i  in  1  access error
- ans_valid_o  out  N_REQ  answer valid, one-hot or zero
- ans_ready_i  in  N_REQ  requester accepts its answer
- ans_rdata_o  out  XLEN  answer data, shared by all requesters
- ans_err_o  out  1  answer error, shared by all requesters

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - Outputs: mem_req_valid_o=0, ans_valid_o=0, req_ready_o=0, mem_req_*=0.
  - State: FIFO empty, count=0, output register empty, RR pointer=0.
- Reset mid-operation aborts everything. Memory is reset together with the core, so no answers are expected afterwards.
- Capture condition: count<MAX_OUTSTANDING AND (output register empty OR mem_req handshake this cycle). No same-cycle bypass from an answer pop.
- Grant (combinational): the first valid requester found scanning from the RR pointer upward with wrap-around.
  - req_ready_o[g]=1 only when the capture condition holds.
- Request handshake (req_valid_i[g] & req_ready_o[g]):
  - The request payload is loaded into the output register.
  - {id=g, drop=flush_i[g]} is pushed into the ID FIFO and count increments.
  - The RR pointer becomes (g+1) mod N_REQ.
- Request latency: 1 cycle from requester handshake to mem_req_valid_o=1.
- Output register stability: mem_req_valid_o and payload stay stable until mem_req_ready_i=1. A flush never withdraws a registered request; only its FIFO drop bit is set.
- Flush:
  - flush_i[i]=1 sets drop on every FIFO entry whose id==i in the same cycle.
  - Flush does not affect the RR pointer or the grant.
  - req_valid_i[i] is ignored while flush_i[i]=1, so no grant goes to i that cycle.
- FIFO head with drop=0:
  - ans_valid_o[id]=mem_ans_valid_i; mem_ans_ready_o=ans_ready_i[id].
  - ans_rdata_o and ans_err_o pass through from mem_ans_*_i.
- FIFO head with drop=1, or flush_i[head.id]=1 in the current cycle:
  - mem_ans_ready_o=1 and ans_valid_o=0; the answer is silently consumed.
- Answer pop on mem_ans handshake: count decrements. If a push happens in the same cycle, count is unchanged.
- Answer with empty FIFO: protocol violation. mem_ans_ready_o=0; an assertion fires in simulation.
- Full: count==MAX_OUTSTANDING forces req_ready_o=0 until a pop.
- Wrap-around: FIFO pointers are log2(MAX_OUTSTANDING) bits and wrap naturally. count is log2(MAX_OUTSTANDING)+1 bits.

Test Plan:
- Reset with all req_valid_i=1: first grant goes to requester 0 (addr 0x1000), mem_req_valid_o rises 1 cycle later; RR pointer=1.
- All requesters valid every cycle, mem_req_ready_i=1, memory answers after 2 cycles: issue order is 0,1,2,0,1,2; each answer returns to the matching ans_valid_o bit with rdata=addr+1.
- mem_req_ready_i=0 for 5 cycles: output register payload stays constant, req_ready_o=0 throughout, no FIFO push. When ready_i rises, the next grant proceeds.
- Memory never answers: after 4 accepted requests count=4 and req_ready_o=0. One answer frees exactly one slot on the following cycle.
- Load buffer issues 2 loads, flush_i[1] pulsed before the answers: both answers are consumed with mem_ans_ready_o=1 and ans_valid_o[1] stays 0. A later load from requester 1 is delivered normally.
- ans_ready_i[2]=0 while a store answer with mem_ans_err_i=1 is at the head: mem_ans_ready_o=0 and the answer is held. When ans_ready_i[2]=1, ans_err_o=1 for one handshake.
